fir_coeff_ctrl: RTL
===================

Name: fir_coeff_ctrl

Overview:
Control stage directly upstream of the transposed 10-tap FIR MAC.
- Generates the 300 kHz sample strobe from the 12 MHz clock.
- Registers each 3-bit input sample on that strobe.
- Holds the active coefficient bank that drives the MAC coefficient inputs.
- Accepts a new coefficient set over a valid/ready write port into a shadow bank, then commits it atomically on a sample boundary so the MAC never sees a mixed set.

Parameters:
CLK_DIV, 40, clock cycles per sample strobe (12 MHz / 40 = 300 kHz); legal range ≥ 2
NUM_TAP, 10, number of coefficients
COEFF_W, 16, coefficient width, two's complement

Ports:
iClk_12M  input  1  system clock, 12 MHz
iRsn  input  1  reset; asynchronous assert, active-low
iUpdateReq  input  1  one-cycle request to start loading a new coefficient set
iWrValid  input  1  write data valid
iWrData  input  COEFF_W  coefficient value, written in tap order 0..NUM_TAP-1
oWrReady  output  1  write data accepted this cycle when high together with iWrValid
iSampleIn  input  3  signed raw input sample
oFirIn  output  3  signed sample, registered on the strobe, drives the MAC FIR input
oEnSample_300k  output  1  one-cycle sample strobe
oCoeff  output  NUM_TAP*COEFF_W  active bank; tap k at bits [k*COEFF_W +: COEFF_W], tap 0 maps to MAC coefficient 1
oBusy  output  1  high whenever state is not IDLE
oCommit  output  1  one-cycle pulse: new bank is visible on oCoeff

Behaviour:
- One clock: iClk_12M. Reset: asynchronous assert, active-low. All registers clear on iRsn low, independent of the clock.
- Reset values:
  - oEnSample_300k = 0, oFirIn = 0, oWrReady = 0, oBusy = 0, oCommit = 0.
  - Active bank and shadow bank = 0 (see Optional Feature).
  - Divider count = 0, write index = 0, state = IDLE.
- Strobe:
  - Free-running counter 0..CLK_DIV-1, wraps to 0.
  - oEnSample_300k is registered and high for exactly one cycle when the count wraps.
  - First strobe is high on the CLK_DIV-th rising edge after reset release; period is CLK_DIV cycles thereafter.
  - Runs in every FSM state.
- Sample path: on each edge where oEnSample_300k is high, oFirIn <= iSampleIn. Otherwise oFirIn holds.
- FSM:
  - IDLE:
    - oWrReady = 0.
    - iUpdateReq -> LOAD, write index = 0.
  - LOAD:
    - oWrReady = 1.
    - On each iWrValid & oWrReady: shadow[index] <= iWrData, index++.
    - When the accepted write is at index NUM_TAP-1 -> WAIT_COMMIT; oWrReady drops the next cycle.
    - iUpdateReq in LOAD restarts: index = 0. Shadow entries already written are kept, but will be overwritten.
    - If iUpdateReq and a write coincide, the restart wins and the write is dropped.
  - WAIT_COMMIT:
    - oWrReady = 0. iUpdateReq is ignored.
    - On the edge where oEnSample_300k is high: active <= shadow, oCommit <= 1, -> IDLE.
- Commit timing: the MAC samples on that same strobe edge with the old bank. The new bank is visible from the following cycle, and the first strobe using it is the next strobe. No strobe ever sees a partially updated bank.
- Writes with iWrValid high while oWrReady is low are ignored and have no side effects.
- oCommit is high for exactly one cycle.
- Reset mid-LOAD or mid-WAIT_COMMIT:
  - Returns to IDLE.
  - Both banks return to their reset contents.
  - No oCommit pulse.

Optional Feature:
Macro FIR_DEFAULT_COEFF_EN.
- Defined: active and shadow banks reset to the default low-pass set, taps 0..9 = -2, 5, -14, 39, 127, 127, 39, -14, 5, -2 (sign-extended to COEFF_W). The filter is usable without a load.
- Undefined: both banks reset to all zeros.
- All other behaviour is identical.

Test Plan:
- Release reset, idle 200 cycles -> oEnSample_300k first high on cycle 40, then every 40 cycles, always 1 cycle wide; oBusy = 0; oCoeff = 0 (macro off).
- iSampleIn = -3 held across a strobe, then changed to 2 between strobes -> oFirIn = -3 from the cycle after that strobe; oFirIn stays -3 until the next strobe, then becomes 2.
- iUpdateReq, then 10 back-to-back writes 1..10 -> oWrReady high for exactly 10 accepted beats. oCoeff is unchanged until the next strobe edge, then equals 1..10. oCommit pulses once, aligned with the new value. oBusy drops the same cycle.
- Load with iWrValid toggled every other cycle, plus writes issued in IDLE and in WAIT_COMMIT -> only the 10 LOAD beats land; stray writes are ignored; the committed bank is exactly the intended values.
- iUpdateReq after 4 writes, then 10 writes of 0x7FFF -> committed bank is all 0x7FFF. Separately, assert iRsn during WAIT_COMMIT -> no oCommit, bank = reset contents, state IDLE.
- With FIR_DEFAULT_COEFF_EN defined, release reset -> oCoeff taps = -2, 5, -14, 39, 127, 127, 39, -14, 5, -2 with no load performed.

Source files
------------

// File: rtl/fir_coeff_ctrl.sv
// fir_coeff_ctrl: sample strobe generator, input sample register and
// double-buffered coefficient bank feeding the transposed 10-tap FIR MAC.
// New coefficient sets are written into a shadow bank over a valid/ready
// port and copied to the active bank in one step on a sample strobe edge.
// Optional macro FIR_DEFAULT_COEFF_EN: both banks reset to a default
// low-pass set instead of all zeros.
module fir_coeff_ctrl #(
    parameter int CLK_DIV = 40,
    parameter int NUM_TAP = 10,
    parameter int COEFF_W = 16
) (
    input  logic                       iClk_12M,
    input  logic                       iRsn,
    input  logic                       iUpdateReq,
    input  logic                       iWrValid,
    input  logic [COEFF_W-1:0]         iWrData,
    output logic                       oWrReady,
    input  logic [2:0]                 iSampleIn,
    output logic [2:0]                 oFirIn,
    output logic                       oEnSample_300k,
    output logic [NUM_TAP*COEFF_W-1:0] oCoeff,
    output logic                       oBusy,
    output logic                       oCommit
);

    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W  = (NUM_TAP > 1) ? $clog2(NUM_TAP) : 1;
    localparam int BANK_W = NUM_TAP * COEFF_W;

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_LOAD        = 2'd1;
    localparam logic [1:0] ST_WAIT_COMMIT = 2'd2;

`ifdef FIR_DEFAULT_COEFF_EN
    // Symmetric low-pass set, tap 9 in the most significant slot.
    localparam logic [10*COEFF_W-1:0] DEFAULT_SET = {
        COEFF_W'(-2),  COEFF_W'(5),   COEFF_W'(-14), COEFF_W'(39),  COEFF_W'(127),
        COEFF_W'(127), COEFF_W'(39),  COEFF_W'(-14), COEFF_W'(5),   COEFF_W'(-2)
    };
    localparam logic [BANK_W-1:0] RESET_BANK = BANK_W'(DEFAULT_SET);
`else
    localparam logic [BANK_W-1:0] RESET_BANK = '0;
`endif

    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic                              strobe_q, strobe_d;
    logic [2:0]                        fir_in_q, fir_in_d;
    logic [1:0]                        state_q, state_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [NUM_TAP-1:0][COEFF_W-1:0]   shadow_q, shadow_d;
    logic [NUM_TAP-1:0][COEFF_W-1:0]   active_q, active_d;
    logic                              commit_q, commit_d;

    // Free-running divider, registered wrap strobe and strobe-qualified sample register.
    always_comb begin
        strobe_d = (cnt_q == CNT_W'(CLK_DIV - 1));
        cnt_d    = strobe_d ? '0 : cnt_q + 1'b1;
        fir_in_d = strobe_q ? iSampleIn : fir_in_q;
    end

    // Load/commit FSM: fills the shadow bank, then swaps it in on a strobe edge.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        active_d = active_q;
        commit_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iUpdateReq) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_LOAD: begin
                // A restart request takes priority over a coincident write.
                if (iUpdateReq) begin
                    idx_d = '0;
                end else if (iWrValid) begin
                    shadow_d[idx_q] = iWrData;
                    if (idx_q == IDX_W'(NUM_TAP - 1)) begin
                        state_d = ST_WAIT_COMMIT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_WAIT_COMMIT: begin
                // The MAC uses the old bank on this strobe edge; the new one is seen from the next.
                if (strobe_q) begin
                    active_d = shadow_q;
                    commit_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            fir_in_q <= '0;
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            shadow_q <= RESET_BANK;
            active_q <= RESET_BANK;
            commit_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            fir_in_q <= fir_in_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            commit_q <= commit_d;
        end
    end

    assign oEnSample_300k = strobe_q;
    assign oFirIn         = fir_in_q;
    assign oCoeff         = active_q;
    assign oCommit        = commit_q;
    assign oBusy          = (state_q != ST_IDLE);
    assign oWrReady       = (state_q == ST_LOAD);

endmodule
